xgmii_rx_frame_checker: RTL and testbench
=========================================

Name: xgmii_rx_frame_checker

Overview:
- Receive-side counterpart of the board's fixed XGMII test-frame generator.
- Parses the 64-bit XGMII RX stream on clk156, taken after lane-0 alignment by xgmiisync.
- Delineates frames, validates preamble, SFD, length and control-character usage, and classifies IPv4/UDP frames against a target destination port.
- Exposes a per-frame result strobe and free-running statistics counters, intended for LEDs and debug.

Parameters:
- UDP_PORT, 16'd9: UDP destination port counted as a match.
- MIN_LEN, 16'd64: minimum good frame length in bytes, dst MAC through FCS inclusive.
- MAX_LEN, 16'd1518: maximum good frame length in bytes.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk156  in  1  156.25 MHz XGMII clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- xgmii_rxd  in  64  RX data; lane n = bits [8n+7:8n]; lane 0 is first on the wire.
- xgmii_rxc  in  8  RX control; bit n flags lane n as a control character.
- rx_done  out  1  one-cycle strobe at the end of each frame.
- rx_len  out  16  byte length of the last frame; valid with rx_done, held until the next rx_done.
- rx_good  out  1  last frame passed all checks; qualified like rx_len.
- rx_udp_match  out  1  last frame was good, EtherType 0x0800, IP protocol 0x11 and UDP dst port == UDP_PORT.
- frame_cnt  out  CNT_W  count of all rx_done events.
- good_cnt  out  CNT_W  count of rx_done with rx_good=1.
- udp_cnt  out  CNT_W  count of rx_done with rx_udp_match=1.
- err_cnt  out  CNT_W  count of rx_done with rx_good=0.

Behaviour:
- Reset (sys_rst_n=0, asynchronous): state=IDLE, all outputs and counters 0. All other logic is synchronous to the rising edge of clk156.
- Start word:
  - Defined as rxc=8'h01, lane0=8'hFB, lanes1-6=8'h55, lane7=8'hD5.
  - A Start character in lane 4 is not supported and is treated as a non-frame word.
- IDLE:
  - A valid start word -> DATA; clear byte count; clear the bad flag.
  - Start character present with a bad preamble or SFD -> DATA with the bad flag set.
  - Any other word stays in IDLE, with no counting.
- DATA, per word, where T = lowest lane with rxc bit set:
  - No control lanes: add 8 to the byte count.
  - rxd lane T = 8'hFD: add T to the byte count, end the frame, -> IDLE.
  - Lane T is any other control character (8'hFE error, 8'h07 idle, 8'hFB start): set bad, end the frame, -> IDLE.
  - In the 8'hFB case only, also start a new frame in the same cycle, exactly as IDLE would on that word.
- Byte count is 16 bits and saturates at 16'hFFFF.
- Field capture, by frame byte offset (byte 0 = first dst MAC byte = lane0 of the first DATA word):
  - EtherType = bytes 12-13, big-endian.
  - IP protocol = byte 23.
  - UDP dst port = bytes 36-37, big-endian.
  - Fields are captured from the DATA word counter; a field the frame ends before is treated as a mismatch.
- Frame end, registered (rx_done asserts the cycle after the terminating word):
  - rx_done=1.
  - rx_len=count.
  - rx_good = !bad && count >= MIN_LEN && count <= MAX_LEN.
  - rx_udp_match = rx_good && fields match.
- Counters update in the same cycle as rx_done and wrap modulo 2^CNT_W.
- rx_done is never high on two consecutive cycles, except for a Start-during-DATA frame immediately followed by an error end.
- No FCS check: the FCS bytes are counted in the length only.
- A frame in progress when reset asserts is discarded and not counted.

Decomposition:
- Package xgmii_pkg holds:
  - Characters: XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_IDLE=8'h07, XGMII_ERROR=8'hFE, PREAMBLE=8'h55, SFD=8'hD5.
  - Protocol constants: ETH_IPV4=16'h0800, IP_UDP=8'h11.
  - State enum {IDLE, DATA}.
- One sub-module, xgmii_lane_decode. It is combinational and takes rxd/rxc, producing:
  - any_ctl.
  - first_ctl_lane[2:0].
  - term_hit: the first control character is FD.
  - start_ok: the word is a valid start word.

Test Plan:
- Generator frame: 64-byte broadcast IPv4/UDP, src/dst port 9, terminate word FD in lane 0 with rxc=8'hFF -> one rx_done, rx_len=64, rx_good=1, rx_udp_match=1, udp_cnt=1.
- Same frame with UDP_PORT=16'd10 -> rx_good=1, rx_udp_match=0, good_cnt=1, udp_cnt=0.
- 56-byte frame, with FD in lane 0 after 7 data words -> rx_len=56, rx_good=0, err_cnt=1.
- 8'hFE with rxc bit 3 set in the 5th data word -> rx_done next cycle, rx_len=35, rx_good=0; following idles produce no rx_done.
- New start word arriving mid-frame, followed by a complete 64-byte frame -> two rx_done: the first has rx_good=0, the second has rx_good=1 and rx_len=64; frame_cnt=2.
- Start word with lane7=8'h55 (bad SFD), then a 64-byte body -> rx_len=64, rx_good=0.
- sys_rst_n pulsed low mid-frame -> all outputs 0 immediately; no rx_done for the partial frame; the next clean frame is counted with frame_cnt=1.

Source files
------------

// File: rtl/xgmii_pkg.sv
package xgmii_pkg;

  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] PREAMBLE    = 8'h55;
  localparam logic [7:0] SFD         = 8'hD5;

  localparam logic [15:0] ETH_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_UDP   = 8'h11;

  typedef enum logic {
    IDLE,
    DATA
  } rx_state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/xgmii_lane_decode.sv
module xgmii_lane_decode
  import xgmii_pkg::*;
(
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  output logic        any_ctl,
  output logic [2:0]  first_ctl_lane,
  output logic        term_hit,
  output logic        start_hit,
  output logic        start_ok
);

  logic       found;
  logic [7:0] first_ctl_char;

  always_comb begin
    any_ctl        = |xgmii_rxc;
    found          = 1'b0;
    first_ctl_lane = '0;
    first_ctl_char = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (xgmii_rxc[i] && !found) begin
        found          = 1'b1;
        first_ctl_lane = 3'(i);
        first_ctl_char = xgmii_rxd[8*i +: 8];
      end
    end
    term_hit  = found && (first_ctl_char == XGMII_TERM);
    start_hit = xgmii_rxc[0] && (xgmii_rxd[7:0] == XGMII_START);
    start_ok  = (xgmii_rxc == 8'h01) &&
                (xgmii_rxd == {SFD, {6{PREAMBLE}}, XGMII_START});
  end

endmodule

// File: rtl/xgmii_rx_frame_checker.sv
module xgmii_rx_frame_checker
  import xgmii_pkg::*;
#(
  parameter logic [15:0] UDP_PORT = 16'd9,
  parameter logic [15:0] MIN_LEN  = 16'd64,
  parameter logic [15:0] MAX_LEN  = 16'd1518,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk156,
  input  logic             sys_rst_n,
  input  logic [63:0]      xgmii_rxd,
  input  logic [7:0]       xgmii_rxc,
  output logic             rx_done,
  output logic [15:0]      rx_len,
  output logic             rx_good,
  output logic             rx_udp_match,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] udp_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic       any_ctl, term_hit, start_hit, start_ok;
  logic [2:0] first_ctl_lane;

  xgmii_lane_decode u_decode (
    .xgmii_rxd      (xgmii_rxd),
    .xgmii_rxc      (xgmii_rxc),
    .any_ctl        (any_ctl),
    .first_ctl_lane (first_ctl_lane),
    .term_hit       (term_hit),
    .start_hit      (start_hit),
    .start_ok       (start_ok)
  );

  rx_state_e        state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic             bad_q, bad_d;
  logic [2:0]       word_q, word_d;
  logic             eth_ok_q, eth_ok_d;
  logic             proto_ok_q, proto_ok_d;
  logic             port_ok_q, port_ok_d;
  logic             rx_done_q, rx_done_d;
  logic [15:0]      rx_len_q, rx_len_d;
  logic             rx_good_q, rx_good_d;
  logic             rx_match_q, rx_match_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] udp_cnt_q, udp_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        fin;
  logic [15:0] fin_len;
  logic        fin_bad;
  logic        fin_good;
  logic        fin_match;

  // Frame end and a restart on FB share one word: the ended frame's result
  // is taken from the old state before the new frame's state is loaded.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    bad_d      = bad_q;
    word_d     = word_q;
    eth_ok_d   = eth_ok_q;
    proto_ok_d = proto_ok_q;
    port_ok_d  = port_ok_q;
    fin        = 1'b0;
    fin_len    = count_q;
    fin_bad    = bad_q;

    if (state_q == DATA) begin
      if (!any_ctl) begin
        count_d = sat_add16(count_q, 16'd8);
        word_d  = (word_q == 3'd7) ? word_q : word_q + 3'd1;
        if (word_q == 3'd1) eth_ok_d   = ({xgmii_rxd[39:32], xgmii_rxd[47:40]} == ETH_IPV4);
        if (word_q == 3'd2) proto_ok_d = (xgmii_rxd[63:56] == IP_UDP);
        if (word_q == 3'd4) port_ok_d  = ({xgmii_rxd[39:32], xgmii_rxd[47:40]} == UDP_PORT);
      end else begin
        fin     = 1'b1;
        fin_len = sat_add16(count_q, {13'd0, first_ctl_lane});
        fin_bad = bad_q || !term_hit;
        state_d = IDLE;
      end
    end

    if ((state_q == IDLE || fin) && start_hit) begin
      state_d    = DATA;
      count_d    = '0;
      bad_d      = !start_ok;
      word_d     = '0;
      eth_ok_d   = 1'b0;
      proto_ok_d = 1'b0;
      port_ok_d  = 1'b0;
    end

    fin_good  = !fin_bad && (fin_len >= MIN_LEN) && (fin_len <= MAX_LEN);
    fin_match = fin_good && eth_ok_q && proto_ok_q && port_ok_q;

    rx_done_d   = fin;
    rx_len_d    = fin ? fin_len   : rx_len_q;
    rx_good_d   = fin ? fin_good  : rx_good_q;
    rx_match_d  = fin ? fin_match : rx_match_q;
    frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, fin};
    good_cnt_d  = good_cnt_q  + {{(CNT_W-1){1'b0}}, fin && fin_good};
    udp_cnt_d   = udp_cnt_q   + {{(CNT_W-1){1'b0}}, fin && fin_match};
    err_cnt_d   = err_cnt_q   + {{(CNT_W-1){1'b0}}, fin && !fin_good};
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      bad_q       <= 1'b0;
      word_q      <= '0;
      eth_ok_q    <= 1'b0;
      proto_ok_q  <= 1'b0;
      port_ok_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_len_q    <= '0;
      rx_good_q   <= 1'b0;
      rx_match_q  <= 1'b0;
      frame_cnt_q <= '0;
      good_cnt_q  <= '0;
      udp_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      bad_q       <= bad_d;
      word_q      <= word_d;
      eth_ok_q    <= eth_ok_d;
      proto_ok_q  <= proto_ok_d;
      port_ok_q   <= port_ok_d;
      rx_done_q   <= rx_done_d;
      rx_len_q    <= rx_len_d;
      rx_good_q   <= rx_good_d;
      rx_match_q  <= rx_match_d;
      frame_cnt_q <= frame_cnt_d;
      good_cnt_q  <= good_cnt_d;
      udp_cnt_q   <= udp_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx_done      = rx_done_q;
  assign rx_len       = rx_len_q;
  assign rx_good      = rx_good_q;
  assign rx_udp_match = rx_match_q;
  assign frame_cnt    = frame_cnt_q;
  assign good_cnt     = good_cnt_q;
  assign udp_cnt      = udp_cnt_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_frame_checker.sv
module tb_xgmii_rx_frame_checker;

  localparam logic [63:0] IDLE_W   = {8{8'h07}};
  localparam logic [63:0] START_W  = 64'hD555_5555_5555_55FB;
  localparam logic [63:0] BADSFD_W = 64'h5555_5555_5555_55FB;

  typedef struct packed {
    logic [15:0] len;
    logic        good;
    logic        match;
  } res_t;

  logic        clk156 = 1'b0;
  logic        sys_rst_n;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;

  logic        rx_done, rx_good, rx_udp_match;
  logic [15:0] rx_len;
  logic [31:0] frame_cnt, good_cnt, udp_cnt, err_cnt;

  logic        rx_done10, rx_good10, rx_udp_match10;
  logic [15:0] rx_len10;
  logic [31:0] frame_cnt10, good_cnt10, udp_cnt10, err_cnt10;

  always #5 clk156 = ~clk156;

  xgmii_rx_frame_checker #(.UDP_PORT(16'd9)) dut (
    .clk156(clk156), .sys_rst_n(sys_rst_n), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
    .rx_done(rx_done), .rx_len(rx_len), .rx_good(rx_good), .rx_udp_match(rx_udp_match),
    .frame_cnt(frame_cnt), .good_cnt(good_cnt), .udp_cnt(udp_cnt), .err_cnt(err_cnt)
  );

  xgmii_rx_frame_checker #(.UDP_PORT(16'd10)) dut10 (
    .clk156(clk156), .sys_rst_n(sys_rst_n), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
    .rx_done(rx_done10), .rx_len(rx_len10), .rx_good(rx_good10), .rx_udp_match(rx_udp_match10),
    .frame_cnt(frame_cnt10), .good_cnt(good_cnt10), .udp_cnt(udp_cnt10), .err_cnt(err_cnt10)
  );

  int n_chk  = 0;
  int n_pass = 0;
  res_t q9[$];
  res_t q10[$];
  int e_frame = 0, e_good = 0, e_udp = 0, e_err = 0, e_udp10 = 0;
  logic [7:0] fb [0:2047];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  always @(negedge clk156) begin
    res_t r;
    if (rx_done === 1'b1) begin
      if (q9.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        r = q9.pop_front();
        chk("len", {16'd0, rx_len}, {16'd0, r.len});
        chk("good", {31'd0, rx_good}, {31'd0, r.good});
        chk("udp_match", {31'd0, rx_udp_match}, {31'd0, r.match});
      end
    end
    if (rx_done10 === 1'b1) begin
      if (q10.size() == 0) chk("unexpected_done10", 32'd1, 32'd0);
      else begin
        r = q10.pop_front();
        chk("len10", {16'd0, rx_len10}, {16'd0, r.len});
        chk("good10", {31'd0, rx_good10}, {31'd0, r.good});
        chk("udp_match10", {31'd0, rx_udp_match10}, {31'd0, r.match});
      end
    end
  end

  task automatic put_word(input logic [63:0] d, input logic [7:0] c);
    xgmii_rxd = d;
    xgmii_rxc = c;
    @(posedge clk156);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put_word(IDLE_W, 8'hFF);
  endtask

  // Broadcast IPv4/UDP frame with given length and UDP destination port.
  task automatic make_frame(input int len, input logic [15:0] port);
    for (int i = 0; i < 2048; i++) fb[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 6; i++) fb[i] = 8'hFF;
    fb[12] = 8'h08; fb[13] = 8'h00;
    fb[14] = 8'h45; fb[22] = 8'h40; fb[23] = 8'h11;
    fb[34] = 8'h00; fb[35] = 8'h09;
    fb[36] = port[15:8]; fb[37] = port[7:0];
    if (len < 0) fb[0] = 8'h00;
  endtask

  function automatic logic [63:0] fword(input int w);
    logic [63:0] d;
    for (int l = 0; l < 8; l++) d[8*l +: 8] = fb[w*8 + l];
    return d;
  endfunction

  task automatic send_body(input int len);
    logic [63:0] d;
    logic [7:0]  c;
    int nfull;
    int rem;
    nfull = len / 8;
    rem   = len % 8;
    for (int w = 0; w < nfull; w++) put_word(fword(w), 8'h00);
    d = IDLE_W;
    c = 8'hFF;
    for (int l = 0; l < rem; l++) begin
      d[8*l +: 8] = fb[nfull*8 + l];
      c[l] = 1'b0;
    end
    d[8*rem +: 8] = 8'hFD;
    put_word(d, c);
  endtask

  task automatic expect_frame(input int len, input logic bad, input logic [15:0] port);
    res_t r;
    logic good;
    good = !bad && len >= 64 && len <= 1518;
    r.len = 16'(len); r.good = good; r.match = good && port == 16'd9;
    q9.push_back(r);
    r.match = good && port == 16'd10;
    q10.push_back(r);
    e_frame++;
    if (good) e_good++; else e_err++;
    if (good && port == 16'd9) e_udp++;
    if (good && port == 16'd10) e_udp10++;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_frame_cnt"}, frame_cnt, 32'(e_frame));
    chk({tag, "_good_cnt"}, good_cnt, 32'(e_good));
    chk({tag, "_udp_cnt"}, udp_cnt, 32'(e_udp));
    chk({tag, "_err_cnt"}, err_cnt, 32'(e_err));
    chk({tag, "_good_cnt10"}, good_cnt10, 32'(e_good));
    chk({tag, "_udp_cnt10"}, udp_cnt10, 32'(e_udp10));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rx_done"}, {31'd0, rx_done}, 32'd0);
    chk({tag, "_rx_len"}, {16'd0, rx_len}, 32'd0);
    chk({tag, "_rx_good"}, {31'd0, rx_good}, 32'd0);
    chk({tag, "_rx_udp_match"}, {31'd0, rx_udp_match}, 32'd0);
    check_counters(tag);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    xgmii_rxd = IDLE_W;
    xgmii_rxc = 8'hFF;
    #1;
    check_zero("reset");
    repeat (3) @(posedge clk156);
    #1;
    sys_rst_n = 1'b1;
    idle(2);

    // Generator frame, 64 bytes, port 9
    make_frame(64, 16'd9);
    expect_frame(64, 1'b0, 16'd9);
    put_word(START_W, 8'h01);
    send_body(64);
    chk("gen_done_latency", {31'd0, rx_done}, 32'd1);
    idle(3);
    check_counters("gen");

    // Short frame, 56 bytes
    make_frame(56, 16'd9);
    expect_frame(56, 1'b0, 16'd9);
    put_word(START_W, 8'h01);
    send_body(56);
    idle(3);
    check_counters("short");

    // Boundary lengths 63 / 1518 / 1519
    make_frame(63, 16'd9);
    expect_frame(63, 1'b0, 16'd9);
    put_word(START_W, 8'h01);
    send_body(63);
    idle(2);
    make_frame(1518, 16'd9);
    expect_frame(1518, 1'b0, 16'd9);
    put_word(START_W, 8'h01);
    send_body(1518);
    idle(2);
    make_frame(1519, 16'd9);
    expect_frame(1519, 1'b0, 16'd9);
    put_word(START_W, 8'h01);
    send_body(1519);
    idle(3);
    check_counters("bounds");

    // Error character in lane 3 of the 5th data word
    make_frame(64, 16'd9);
    expect_frame(35, 1'b1, 16'd9);
    put_word(START_W, 8'h01);
    for (int w = 0; w < 4; w++) put_word(fword(w), 8'h00);
    begin
      logic [63:0] d;
      d = fword(4);
      d[31:24] = 8'hFE;
      put_word(d, 8'h08);
    end
    chk("fe_done_next", {31'd0, rx_done}, 32'd1);
    chk("fe_len_next", {16'd0, rx_len}, 32'd35);
    idle(5);
    check_counters("fe");

    // Restart mid-frame, then a complete frame
    make_frame(64, 16'd9);
    expect_frame(24, 1'b1, 16'd9);
    expect_frame(64, 1'b0, 16'd9);
    put_word(START_W, 8'h01);
    for (int w = 0; w < 3; w++) put_word(fword(w), 8'h00);
    put_word(START_W, 8'h01);
    send_body(64);
    idle(3);
    check_counters("restart");

    // Bad SFD
    make_frame(64, 16'd9);
    expect_frame(64, 1'b1, 16'd9);
    put_word(BADSFD_W, 8'h01);
    send_body(64);
    idle(3);
    check_counters("badsfd");

    // Port 10 frame: matches only on the second instance
    make_frame(64, 16'd10);
    expect_frame(64, 1'b0, 16'd10);
    put_word(START_W, 8'h01);
    send_body(64);
    idle(3);
    check_counters("port10");

    // Reset mid-frame
    make_frame(64, 16'd9);
    put_word(START_W, 8'h01);
    for (int w = 0; w < 3; w++) put_word(fword(w), 8'h00);
    sys_rst_n = 1'b0;
    #1;
    e_frame = 0; e_good = 0; e_udp = 0; e_err = 0; e_udp10 = 0;
    check_zero("midreset");
    @(posedge clk156);
    #1;
    sys_rst_n = 1'b1;
    for (int w = 3; w < 8; w++) put_word(fword(w), 8'h00);
    put_word(IDLE_W | 64'h0000_0000_0000_00FA, 8'hFF);
    idle(3);
    check_counters("post_reset_idle");
    expect_frame(64, 1'b0, 16'd9);
    put_word(START_W, 8'h01);
    send_body(64);
    idle(3);
    check_counters("post_reset");

    for (int i = 0; i < 20 && (q9.size() != 0 || q10.size() != 0); i++) idle(1);
    chk("pending_q9", 32'(q9.size()), 32'd0);
    chk("pending_q10", 32'(q10.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
